// File: rtl/seq_step_pkg.sv
// Shared types and constants for the sequence step controller.
// Holds the FSM state encoding, the datapath value limits, the lap counter
// width and the phase-evaluation helper used at each post-step check.
package seq_step_pkg;

    localparam int SEQ_W = 6;
    localparam logic [SEQ_W-1:0] SEQ_MAX = 6'd63;
    localparam int LAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic dir_n;    // direction after the check
        logic lap_inc;  // a down phase just finished at zero
    } phase_t;

    // Phase rules, first match wins: bottom of a down phase closes a lap,
    // zero while going up turns down, and the top value forces a turn down
    // so the datapath never wraps past its maximum.
    function automatic phase_t phase_eval(input logic dir, input logic [SEQ_W-1:0] val);
        phase_t r;
        r.dir_n   = dir;
        r.lap_inc = 1'b0;
        if (!dir && (val == 6'd0)) begin
            r.dir_n   = 1'b1;
            r.lap_inc = 1'b1;
        end else if (dir && (val == 6'd0)) begin
            r.dir_n = 1'b0;
        end else if (dir && (val == SEQ_MAX)) begin
            r.dir_n = 1'b0;
        end else begin
            r.dir_n = dir;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_step_ctrl_if.sv
// Control/status bundle between the board-level driver (master) and the
// sequence step controller (slave).
interface seq_step_ctrl_if #(
    parameter int DIV_W = 4
);
    import seq_step_pkg::*;

    logic              start;
    logic              pause;
    logic [DIV_W-1:0]  div;
    logic [SEQ_W-1:0]  seq_val;
    logic              step_en;
    logic              seq_clr;
    logic              dir;
    logic [2:0]        state;
    logic [LAP_W-1:0]  lap_cnt;
    logic              done;

    modport master (
        output start, pause, div, seq_val,
        input  step_en, seq_clr, dir, state, lap_cnt, done
    );

    modport slave (
        input  start, pause, div, seq_val,
        output step_en, seq_clr, dir, state, lap_cnt, done
    );

endinterface

// File: rtl/seq_step_ctrl_divider.sv
// Step-period divider: captures the period on load (0 is promoted to 1 so
// the period is never shorter than two cycles), counts while running,
// freezes otherwise, and emits a registered tick while the count sits at
// the captured period.
module step_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count wraps to zero once the captured period is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == div_q) begin
            cnt_d = {DIV_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
        tick_d = (cnt_d == div_q);
    end

    // Period capture, count advance/freeze and registered tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= {{(DIV_W-1){1'b0}}, 1'b1};
            cnt_q  <= {DIV_W{1'b0}};
            tick_q <= 1'b0;
        end else if (load_i) begin
            div_q  <= (div_i == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_i;
            cnt_q  <= {DIV_W{1'b0}};
            tick_q <= 1'b0;
        end else if (run_i) begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end else begin
            cnt_q  <= cnt_q;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/seq_step_ctrl.sv
// Sequence step controller: paces the up/down sequence datapath, owns the
// start/pause/done sequencing, tracks the phase from the datapath value and
// counts completed laps. All outputs come straight from flops.
// Optional lap limit: define SEQ_STEP_CTRL_LAP_LIMIT_EN to stop in DONE once
// LAP_MAX laps complete; otherwise DONE is unreachable and done stays 0.
module seq_step_ctrl
    import seq_step_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int LAP_MAX = 3
) (
    input  logic           clk,
    input  logic           rst,
    seq_step_ctrl_if.slave bus
);

`ifdef SEQ_STEP_CTRL_LAP_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif
    localparam logic [LAP_W-1:0] LAP_LIMIT = LAP_W'(LAP_MAX);

    state_e           state_q;
    state_e           state_d;
    logic             dir_q;
    logic             dir_d;
    logic [LAP_W-1:0] lap_q;
    logic [LAP_W-1:0] lap_d;
    logic             chk_q;
    logic             chk_d;
    logic             clr_q;
    logic             done_q;

    logic             step_en;
    logic             div_load;
    logic             div_run;
    phase_t           ph;
    logic             lap_inc;
    logic [LAP_W-1:0] lap_next;
    logic             limit_hit;

    assign ph        = phase_eval(dir_q, bus.seq_val);
    assign lap_inc   = chk_q & ph.lap_inc;
    assign lap_next  = lap_q + {{(LAP_W-1){1'b0}}, lap_inc};
    assign limit_hit = LIMIT_EN & lap_inc & (lap_next == LAP_LIMIT);

    // Next-state, phase and lap logic; start overrides everything else.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lap_d   = lap_q;
        chk_d   = chk_q;
        if (bus.start) begin
            state_d = ST_LOAD;
            dir_d   = 1'b1;
            lap_d   = {LAP_W{1'b0}};
            chk_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                    chk_d   = 1'b0;
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                    dir_d   = 1'b1;
                    lap_d   = {LAP_W{1'b0}};
                    chk_d   = 1'b0;
                end
                ST_RUN: begin
                    if (chk_q) begin
                        dir_d = ph.dir_n;
                        lap_d = lap_next;
                        chk_d = 1'b0;
                    end else begin
                        chk_d = step_en;
                    end
                    if (limit_hit) begin
                        state_d = ST_DONE;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    chk_d   = 1'b0;
                end
            endcase
        end
    end

    // Divider loads during LOAD and advances only on edges that stay in RUN.
    assign div_load = (state_q == ST_LOAD);
    assign div_run  = (state_d == ST_RUN) &&
                      ((state_q == ST_RUN) || (state_q == ST_PAUSE));

    step_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .load_i (div_load),
        .div_i  (bus.div),
        .run_i  (div_run),
        .tick_o (step_en)
    );

    // FSM state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b1;
            lap_q   <= {LAP_W{1'b0}};
            chk_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            lap_q   <= lap_d;
            chk_q   <= chk_d;
            clr_q   <= (state_d == ST_LOAD);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.step_en = step_en;
    assign bus.seq_clr = clr_q;
    assign bus.dir     = dir_q;
    assign bus.state   = state_q;
    assign bus.lap_cnt = lap_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed self-checking bench for seq_step_ctrl (DIV_W=4, LAP_MAX=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_step_ctrl;
    import seq_step_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seq_step_ctrl_if #(.DIV_W(4)) bus();

    seq_step_ctrl #(.DIV_W(4), .LAP_MAX(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One-cycle start; returns at the falling edge of the LOAD cycle (j=1).
    task automatic start_seq(input logic [3:0] d);
        @(negedge clk);
        bus.div   = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        exp_v = {3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.div = 4'd0; bus.seq_val = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done} !== exp_v) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", {bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done}, exp_v);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done} !== exp_v) begin
                failures++;
                $display("FAIL idle cycle=%0d got=%b exp=%b", i, {bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done}, exp_v);
            end
        end
    endtask

    task automatic test_normal_stepping();
        logic exp_step;
        bus.seq_val = 6'd5;
        start_seq(4'd3);
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) @(negedge clk);
            exp_step = (j == 5) || (j == 9) || (j == 13);
            checks++;
            if (bus.step_en !== exp_step) begin
                failures++;
                $display("FAIL normal_step_en j=%0d got=%b exp=%b", j, bus.step_en, exp_step);
            end
            checks++;
            if (bus.seq_clr !== (j == 1)) begin
                failures++;
                $display("FAIL normal_seq_clr j=%0d got=%b exp=%b", j, bus.seq_clr, (j == 1));
            end
            if (j <= 2) begin
                checks++;
                if (bus.state !== ((j == 1) ? 3'd1 : 3'd2)) begin
                    failures++;
                    $display("FAIL normal_state j=%0d got=%0d exp=%0d", j, bus.state, (j == 1) ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic exp_step;
        logic [2:0] exp_st;
        bus.seq_val = 6'd5;
        start_seq(4'd3);
        for (int j = 1; j <= 20; j++) begin
            if (j > 1) @(negedge clk);
            exp_step = (j == 5) || (j == 19);
            checks++;
            if (bus.step_en !== exp_step) begin
                failures++;
                $display("FAIL pause_step_en j=%0d got=%b exp=%b", j, bus.step_en, exp_step);
            end
            if ((j == 8) || (j == 17) || (j == 18)) begin
                exp_st = (j == 18) ? 3'd2 : 3'd3;
                checks++;
                if (bus.state !== exp_st) begin
                    failures++;
                    $display("FAIL pause_state j=%0d got=%0d exp=%0d", j, bus.state, exp_st);
                end
            end
            if (j == 7)  bus.pause = 1'b1;
            if (j == 17) bus.pause = 1'b0;
        end
    endtask

    task automatic test_phase_lap();
        logic       exp_step;
        logic       exp_dir;
        logic [3:0] exp_lap;
        bus.seq_val = 6'd5;
        start_seq(4'd3);
        for (int j = 1; j <= 19; j++) begin
            if (j > 1) @(negedge clk);
            exp_step = (j == 5) || (j == 9) || (j == 13) || (j == 17);
            exp_dir  = (j < 7) ? 1'b1 : (j < 15) ? 1'b0 : (j < 19) ? 1'b1 : 1'b0;
            exp_lap  = (j < 15) ? 4'd0 : 4'd1;
            checks++;
            if (bus.step_en !== exp_step) begin
                failures++;
                $display("FAIL phase_step_en j=%0d got=%b exp=%b", j, bus.step_en, exp_step);
            end
            checks++;
            if (bus.dir !== exp_dir) begin
                failures++;
                $display("FAIL phase_dir j=%0d got=%b exp=%b", j, bus.dir, exp_dir);
            end
            checks++;
            if (bus.lap_cnt !== exp_lap) begin
                failures++;
                $display("FAIL phase_lap j=%0d got=%0d exp=%0d", j, bus.lap_cnt, exp_lap);
            end
            if (j == 5)  bus.seq_val = 6'd63;
            if (j == 9)  bus.seq_val = 6'd10;
            if (j == 13) bus.seq_val = 6'd0;
        end
    endtask

    // div=0 gives period 2; seq_val held at 0 closes a lap every 4 cycles.
    task automatic test_lap_limit();
        logic       exp_step;
        logic       exp_done;
        logic [2:0] exp_st;
        bus.seq_val = 6'd0;
        start_seq(4'd0);
        for (int j = 1; j <= 16; j++) begin
            if (j > 1) @(negedge clk);
`ifdef SEQ_STEP_CTRL_LAP_LIMIT_EN
            exp_step = (j >= 3) && (j <= 9) && (j % 2 == 1);
            exp_done = (j >= 11);
            exp_st   = (j >= 11) ? 3'd4 : (j == 1) ? 3'd1 : 3'd2;
`else
            exp_step = (j >= 3) && (j % 2 == 1);
            exp_done = 1'b0;
            exp_st   = (j == 1) ? 3'd1 : 3'd2;
`endif
            checks++;
            if (bus.step_en !== exp_step) begin
                failures++;
                $display("FAIL lap_step_en j=%0d got=%b exp=%b", j, bus.step_en, exp_step);
            end
            checks++;
            if (bus.done !== exp_done) begin
                failures++;
                $display("FAIL lap_done j=%0d got=%b exp=%b", j, bus.done, exp_done);
            end
            checks++;
            if (bus.state !== exp_st) begin
                failures++;
                $display("FAIL lap_state j=%0d got=%0d exp=%0d", j, bus.state, exp_st);
            end
            if (j == 11) begin
                checks++;
                if (bus.lap_cnt !== 4'd2) begin
                    failures++;
                    $display("FAIL lap_count j=%0d got=%0d exp=2", j, bus.lap_cnt);
                end
            end
        end
        start_seq(4'd3);
        checks++;
        if ({bus.state, bus.lap_cnt, bus.done, bus.seq_clr} !== {3'd1, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lap_restart got=%b exp=%b", {bus.state, bus.lap_cnt, bus.done, bus.seq_clr}, {3'd1, 4'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_start_pause();
        bus.seq_val = 6'd5;
        start_seq(4'd3);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state !== 3'd2) begin
            failures++;
            $display("FAIL sp_pre_state got=%0d exp=2", bus.state);
        end
        bus.start = 1'b1;
        bus.pause = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        checks++;
        if ({bus.state, bus.seq_clr} !== {3'd1, 1'b1}) begin
            failures++;
            $display("FAIL sp_load got=%b exp=%b", {bus.state, bus.seq_clr}, {3'd1, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (bus.state !== 3'd2) begin
            failures++;
            $display("FAIL sp_run got=%0d exp=2", bus.state);
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] exp_v;
        exp_v = {3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        bus.seq_val = 6'd5;
        start_seq(4'd3);
        for (int j = 2; j <= 9; j++) begin
            @(negedge clk);
            if (j == 5) bus.seq_val = 6'd63;
        end
        checks++;
        if ({bus.step_en, bus.dir, bus.state} !== {1'b1, 1'b0, 3'd2}) begin
            failures++;
            $display("FAIL ar_pre got=%b exp=%b", {bus.step_en, bus.dir, bus.state}, {1'b1, 1'b0, 3'd2});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done} !== exp_v) begin
            failures++;
            $display("FAIL ar_async got=%b exp=%b", {bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done}, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done} !== exp_v) begin
            failures++;
            $display("FAIL ar_idle got=%b exp=%b", {bus.state, bus.dir, bus.lap_cnt, bus.step_en, bus.seq_clr, bus.done}, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_normal_stepping();
        test_pause();
        test_phase_lap();
        test_lap_limit();
        test_start_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_step_ctrl.md
# seq_step_ctrl

Controller for the 6-bit up/down sequence datapath. It paces the datapath with a programmable step divider and owns the start, pause and done sequencing. It tracks the up/down phase from the datapath's output value and counts completed laps. It sits between the board-level control inputs and the sequence register: it drives that register's step enable, clear and direction, and reads its current value back.

## Interface
- `DIV_W`, default 4: width of the step-period input.
- `LAP_MAX`, default 3: number of completed laps before DONE; only used with the lap limit enabled.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled every cycle; restarts the sequence from any state.
- `pause`  in  1  level; freezes stepping while high in RUN.
- `div`  in  DIV_W  step period minus one; captured in LOAD.
- `seq_val`  in  6  current registered value of the datapath.
- `step_en`  out  1  one-cycle pulse; the datapath advances one term.
- `seq_clr`  out  1  one-cycle pulse; the datapath clears its value and term index.
- `dir`  out  1  1 = up phase, 0 = down phase.
- `state`  out  3  current FSM state code.
- `lap_cnt`  out  4  completed laps.
- `done`  out  1  high while in DONE.

## Operation
- States and encodings: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.
- IDLE:
  - All pulse outputs are 0.
  - `start`=1 moves to LOAD.
- LOAD (exactly one cycle):
  - `seq_clr`=1.
  - Capture `div`; a captured value of 0 is stored as 1, so the minimum step period is 2 cycles.
  - `dir` is set to 1, `lap_cnt` to 0 and the divider count to 0.
  - Next state is RUN.
- RUN:
  - The divider count increments each cycle.
  - When the count equals the captured `div`, `step_en`=1 for that cycle and the count returns to 0.
- Phase check: in the cycle after each `step_en`, `seq_val` is evaluated. The rules are applied in the order below.
  - If `dir`=0 and `seq_val`=0: set `dir` to 1 and increment `lap_cnt` (wraps modulo 16).
  - If `dir`=1 and `seq_val`=0: set `dir` to 0.
  - If `dir`=1 and `seq_val`=63: set `dir` to 0 (saturation guard).
  - Otherwise `dir` is unchanged.
- PAUSE:
  - RUN with `pause`=1 enters PAUSE on the next edge.
  - In PAUSE, the divider count and any pending phase check are frozen and `step_en`=0.
  - `pause`=0 returns to RUN, and the divider resumes from its frozen count.
- DONE:
  - `done`=1 and `step_en`=0.
  - `seq_val` is not checked.
  - `dir` and `lap_cnt` hold their values.
- Simultaneous events:
  - `start` has priority over `pause` and over the phase check. A `start` in RUN, PAUSE or DONE goes to LOAD, discarding divider and phase state.
  - `pause` asserted in the same cycle as `step_en` does not cancel that pulse.
- Reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Reset values: `state`=IDLE, `step_en`=0, `seq_clr`=0, `dir`=1, `lap_cnt`=0, `done`=0.
- `start` sampled at edge N gives LOAD during cycle N+1 (`seq_clr` high) and RUN from N+2.
- The first `step_en` occurs in cycle N+2+div, with div as captured.
- After that, `step_en` repeats every div+1 cycles.
- A `dir` change is registered at the check edge. Because the period is at least 2 cycles, the new `dir` is stable before the next `step_en`.
- `done` rises in the cycle after the check that completes lap `LAP_MAX`.
- All outputs are registered. There is no combinational path from `seq_val` to any output.

## Configuration
- `SEQ_STEP_CTRL_LAP_LIMIT_EN` defined:
  - The check that brings `lap_cnt` to `LAP_MAX` transitions to DONE.
  - `done` is functional.
- `SEQ_STEP_CTRL_LAP_LIMIT_EN` undefined:
  - DONE is unreachable and `done` is tied to 0.
  - The block runs indefinitely, and `lap_cnt` wraps modulo 16.

## Structure
- Shared package `seq_step_pkg` holds:
  - the state enum (IDLE..DONE, 3 bits);
  - `SEQ_W`=6 and `SEQ_MAX`=63;
  - the `lap_cnt` width constant 4.
- One sub-module, `step_divider`. It contains the divider counter with load, freeze and tick output.
- The FSM and phase logic stay in the top-level block.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 3 cycles, release it, keep `start`=0 for 20 cycles.
  - Required: `state`=0, `dir`=1, `lap_cnt`=0, and `step_en`, `seq_clr`, `done` all 0 throughout.
- Normal stepping:
  - Stimulus: `div`=3, one-cycle `start` at edge N.
  - Required: `seq_clr` high in cycle N+1 only; `step_en` in cycles N+5, N+9, N+13; no other pulses.
- Pause:
  - Stimulus: `div`=3; hold `pause` high for 10 cycles starting 2 cycles after a `step_en`.
  - Required: no `step_en` while paused; the next pulse comes 2 cycles after `pause` falls.
- Phase and lap counting:
  - Stimulus: model drives `seq_val` 63 after a step with `dir`=1, then 0 after a later step.
  - Required: `dir` goes to 0, then returns to 1, and `lap_cnt` goes to 1.
- Lap limit:
  - Stimulus: macro defined, `LAP_MAX`=2, two full laps.
  - Required: `done`=1 and `state`=4; no `step_en` afterwards; a `start` returns to LOAD with `lap_cnt`=0.
- Edge cases:
  - `div`=0: `step_en` comes every 2 cycles.
  - Asynchronous `rst` mid-RUN: all outputs reach reset values before the next clock edge.
  - `start` and `pause` asserted together in RUN: the next state is LOAD.
